// File: rtl/wgt_load_ctrl_pkg.sv
// Shared definitions for the weight-load controller: FSM state codes and sizing helpers.
// Latency: n/a (package). Backpressure: n/a (package).
// Contents: state_t plus ST_* codes, total_beats(), id_fits().
package wgt_load_ctrl_pkg;

  // State codes kept as plain localparams so older code that compares raw values keeps working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of load beats needed to fill the whole chain.
  function automatic int total_beats(input int pe_num, input int wgt_per_pe);
    return pe_num * wgt_per_pe;
  endfunction

  // True when every PE ID on the chain can be encoded in the load ID field.
  function automatic bit id_fits(input int pe_num, input int id_width);
    return pe_num <= (1 << id_width);
  endfunction

endpackage

// File: rtl/wgt_load_seq.sv
// Beat sequencer: counts accepted load beats and derives target PE ID, slot and last-PE flag.
// Latency: outputs are combinational from the count register; the count moves one edge after adv.
// Backpressure: none of its own; it only advances when the parent accepts a beat.
// Ports: clk, rst (sync, high), clr (restart at beat 0), adv (beat accepted),
//        id (target PE), slot (weight slot within PE), last (current beat targets the final PE).
module wgt_load_seq
  import wgt_load_ctrl_pkg::*;
#(
  parameter int PE_NUM     = 16,
  parameter int ID_WIDTH   = 6,
  parameter int WGT_PER_PE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  output logic [ID_WIDTH-1:0] id,
  output logic                slot,
  output logic                last
);

  localparam int TOTAL = total_beats(PE_NUM, WGT_PER_PE);
  localparam int CNT_W = (TOTAL > 2) ? $clog2(TOTAL) : 1;

  logic [CNT_W-1:0] cnt;

  // Two weights per PE: the low count bit is the slot, the rest is the PE ID.
  assign slot = cnt[0];
  assign id   = ID_WIDTH'(cnt >> 1);
  assign last = (id == ID_WIDTH'(PE_NUM - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (adv) begin
      // Wrap explicitly after the final beat so non-power-of-two chains also restart at 0.
      if (last && slot) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wgt_load_ctrl.sv
// Head-of-chain driver: streams weights into PE 0 as (id, data) load beats, then issues slot pops.
// Latency: 1 cycle from accepted weight to load beat, 1 cycle from pop request to pop/drop pulse.
// Backpressure: o_wgt_rdy is high only in LOAD; pops outside a loaded IDLE are dropped, never queued.
// Ports: clk/rst; i_start/o_busy/o_done control; i_wgt_vld/i_wgt_data/o_wgt_rdy weight stream;
//        o_load_vld/o_load_id/o_load_data to PE 0; i_pop_req/o_pop_vld/o_pop_sel/o_pop_drop pop path.
module wgt_load_ctrl
  import wgt_load_ctrl_pkg::*;
#(
  parameter int PE_NUM        = 16,
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int WGT_PER_PE    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_wgt_vld,
  input  logic [IN_DATA_WIDTH-1:0] i_wgt_data,
  output logic                     o_wgt_rdy,
  output logic                     o_load_vld,
  output logic [ID_WIDTH-1:0]      o_load_id,
  output logic [IN_DATA_WIDTH-1:0] o_load_data,
  input  logic                     i_pop_req,
  output logic                     o_pop_vld,
  output logic                     o_pop_sel,
  output logic                     o_pop_drop
);

  if (!id_fits(PE_NUM, ID_WIDTH)) begin : g_id_range_chk
    $error("wgt_load_ctrl: PE_NUM does not fit in ID_WIDTH");
  end
  if (WGT_PER_PE != 2) begin : g_wgt_per_pe_chk
    $error("wgt_load_ctrl: the PE slot index is 1 bit, WGT_PER_PE must be 2");
  end

  state_t              state;
  logic                loaded;
  logic [ID_WIDTH-1:0] seq_id;
  logic                seq_slot;
  logic                seq_last;
  logic                start_load;
  logic                beat_acc;
  logic                final_beat;
  logic                pop_ok;

  assign o_wgt_rdy  = (state == ST_LOAD);
  assign o_busy     = (state == ST_LOAD);
  assign o_done     = (state == ST_DONE);

  assign start_load = (state == ST_IDLE) && i_start;
  assign beat_acc   = i_wgt_vld && o_wgt_rdy;
  // Final beat is slot 1 of the last PE on the chain.
  assign final_beat = beat_acc && seq_last && seq_slot;
  // Evaluated on the pre-edge state, so a pop arriving with i_start still uses the old weights.
  assign pop_ok     = i_pop_req && (state == ST_IDLE) && loaded;

  wgt_load_seq #(
    .PE_NUM     (PE_NUM),
    .ID_WIDTH   (ID_WIDTH),
    .WGT_PER_PE (WGT_PER_PE)
  ) u_seq (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_load),
    .adv  (beat_acc),
    .id   (seq_id),
    .slot (seq_slot),
    .last (seq_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      loaded <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_LOAD;
            loaded <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (final_beat) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          loaded <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Load beat register: id/data hold between beats, only the valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_load_vld  <= 1'b0;
      o_load_id   <= '0;
      o_load_data <= '0;
    end else begin
      o_load_vld <= beat_acc;
      if (beat_acc) begin
        o_load_id   <= seq_id;
        o_load_data <= i_wgt_data;
      end
    end
  end

  // o_pop_sel mirrors the PE slot index; both are cleared only by the shared rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pop_vld  <= 1'b0;
      o_pop_sel  <= 1'b0;
      o_pop_drop <= 1'b0;
    end else begin
      o_pop_vld  <= pop_ok;
      o_pop_drop <= i_pop_req && !pop_ok;
      if (pop_ok) begin
        o_pop_sel <= ~o_pop_sel;
      end
    end
  end

endmodule
